// File: rtl/param_memory_pkg.sv
// Shared types and helpers for the parametrised byte-enable memory.
package param_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_array_be.sv
// Raw word storage: one clocked access per cycle, byte-enable merge on write,
// registered read data that holds its value until the next read.
module mem_array_be
  import param_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_memory.sv
// Single-port memory with valid/ready request/response handshake, a one-entry
// response register and an optional post-reset clear sequence.
//
// state    | meaning
// ST_CLEAR | zeroing word ptr_q each cycle, requests blocked
// ST_IDLE  | accepting requests when the response slot is free or popping
module param_memory
  import param_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [be_width(DATA_WIDTH)-1:0] req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_write,
  output logic                          rsp_err,
  output logic                          busy_clear
);

  localparam int BeW = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_rd_q, rsp_rd_d;

  logic                  accept, in_range;
  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [BeW-1:0]        mem_be;

  assign in_range   = ({1'b0, req_addr} < DEPTH_EXT);
  assign req_ready  = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept     = req_valid && req_ready;
  assign busy_clear = (state_q == ST_CLEAR);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = req_addr;
    mem_wdata   = req_wdata;
    mem_be      = req_be;
    case (state_q)
      ST_CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        mem_be    = '1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          // Out-of-range requests still answer, but never touch the array.
          mem_en      = in_range;
          mem_we      = req_write;
          rsp_valid_d = 1'b1;
          rsp_write_d = req_write;
          rsp_err_d   = !in_range;
          rsp_rd_d    = !req_write && in_range;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // The reset edge itself must leave the array untouched.
  mem_array_be #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .BE_WIDTH  (BeW)
  ) u_array (
    .clk    (clk),
    .en_i   (mem_en && rst_n),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .be_i   (mem_be),
    .rdata_o(mem_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_param_memory.sv
// Randomised scoreboard bench for param_memory (DEPTH=768 inside a 10-bit space).
module tb_param_memory;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 768;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;
  logic          rsp_err;
  logic          busy_clear;

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err), .busy_clear(busy_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic          e;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_acc = 0;
  int            rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake; checks stability under back-pressure.
  logic          hold_prev = 1'b0;
  logic [17:0]   hold_val;
  always begin
    @(posedge clk);
    #5;
    if (hold_prev) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_stable", {14'd0, rsp_write, rsp_err, rsp_rdata}, {14'd0, hold_val});
    end
    hold_prev = 1'b0;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp", {14'd0, rsp_write, rsp_err, rsp_rdata}, {14'd0, e.w, e.e, e.d});
      end
    end else if (rsp_valid) begin
      hold_prev = 1'b1;
      hold_val  = {rsp_write, rsp_err, rsp_rdata};
    end
  end

  task automatic model_accept(input logic w, input int a, input logic [DW-1:0] d, input logic [1:0] be);
    exp_t e;
    e.w = w;
    e.e = (a >= DEPTH);
    e.d = '0;
    if (!e.e) begin
      if (w) begin
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
        if (be[1]) ref_mem[a][15:8] = d[15:8];
      end else begin
        e.d = ref_mem[a];
      end
    end
    exp_q.push_back(e);
    last_acc = cyc;
  endtask

  // Entered at posedge+3; returns at posedge+3 after the accepting edge with req_valid still high.
  task automatic issue(input logic w, input int a, input logic [DW-1:0] d, input logic [1:0] be);
    int tries = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    #1;
    while (!req_ready && tries < 200) begin
      @(posedge clk);
      #4;
      tries++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      model_accept(w, a, d, be);
    end
    @(posedge clk);
    #3;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_be    = 2'($urandom);
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #3;
  endtask

  // Counts sampled busy cycles after reset release; a pending write must stay blocked.
  task automatic count_clear(input int limit, output int n, output int viol);
    n = 0;
    viol = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = '0;
    req_wdata = 16'hFFFF;
    req_be    = 2'b11;
    while (busy_clear && n < limit) begin
      n++;
      if (req_ready) viol++;
      @(posedge clk);
      #5;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int n, viol, a0, w;
    do_reset();
    chk("rst_busy", {31'd0, busy_clear}, 32'd1);
    chk("rst_rsp", {13'd0, rsp_valid, rsp_write, rsp_err, rsp_rdata}, 32'd0);
    count_clear(500, n, viol);
    chk("partial_clear", n, 500);
    do_reset();
    count_clear(5000, n, viol);
    chk("clear_cycles", n, DEPTH);
    chk("ready_in_clear", viol, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    idle();
    issue(0, 0, 0, 0);
    issue(0, DEPTH - 1, 0, 0);
    issue(1, 0, 16'h1234, 2'b11);
    issue(1, DEPTH - 1, 16'h4321, 2'b11);
    issue(0, 0, 0, 0);
    issue(0, DEPTH - 1, 0, 0);
    issue(1, 5, 16'hAAAA, 2'b11);
    issue(1, 5, 16'h0055, 2'b01);
    issue(0, 5, 0, 0);
    issue(1, 5, 16'hFFFF, 2'b00);
    issue(0, 5, 0, 0);
    issue(0, DEPTH, 0, 0);
    issue(1, 'h300, 16'hBEEF, 2'b11);
    issue(0, 'h3FF, 0, 0);
    issue(0, 0, 0, 0);
    idle();

    rdy_mode = 1;
    idle();
    issue(0, 0, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_data", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'h1234});
      @(posedge clk);
      #3;
    end
    rdy_mode = 0;
    idle();
    issue(0, 0, 0, 0);
    a0 = last_acc;
    issue(0, DEPTH - 1, 0, 0);
    chk("b2b_cycles", last_acc - a0, 1);
    idle();

    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int a;
      if ($urandom_range(0, 3) == 0) idle();
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(DEPTH, 1023);
        1, 2, 3: a = $urandom_range(DEPTH - 4, DEPTH - 1);
        default: a = $urandom_range(0, 7);
      endcase
      w = $urandom_range(0, 1);
      issue(1'(w), a, DW'($urandom), 2'($urandom));
    end
    idle();
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle();
      n++;
    end
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
- Parametrised single-port synchronous memory: generalised width/depth, per-byte write enables.
- Valid/ready request/response handshake with one-entry response buffer and back-pressure.
- Optional post-reset clear sequencer that zeroes the array.
- Sits between core load/store logic and storage; supersedes the fixed 16-bit x 1K memory.

Parameters:
- DATA_WIDTH, 16, word width in bits; multiple of 8.
- ADDR_WIDTH, 10, address bus width.
- DEPTH, 1024, implemented words; must be ≤ 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset before accepting requests.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for write responses.
- rsp_write  out  1  response belongs to a write.
- rsp_err  out  1  request address ≥ DEPTH.
- busy_clear  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n low at a rising edge): rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0, clear pointer=0.
  - busy_clear=1 if CLEAR_ON_RESET, else 0.
  - Array contents untouched by reset itself.
- FSM states: CLEAR, IDLE.
  - Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
  - CLEAR: writes 0 to word ptr each cycle and increments ptr. After writing word DEPTH-1, moves to IDLE; busy_clear drops the next cycle.
  - Total CLEAR duration is exactly DEPTH cycles.
  - Reset asserted mid-CLEAR restarts CLEAR at ptr 0.
- req_ready = (state==IDLE) && (!rsp_valid || rsp_ready). It is 0 throughout CLEAR.
- Accept: a request is accepted on an edge where req_valid && req_ready.
- Write accept:
  - Bytes with req_be[i]=1 are updated; all other bytes are preserved.
  - req_be all-zero still produces a response and does not modify the array.
- Read accept: rsp_rdata = array contents before that edge, registered. Latency is 1 cycle: rsp_valid is high the cycle after accept.
- Every accepted request produces exactly one response, in order.
- Out-of-range request (addr ≥ DEPTH): no array access. Response has rsp_err=1 and rsp_rdata=0.
- Response hold: rsp_valid && !rsp_ready holds rsp_* stable, and req_ready=0.
- Response pop: rsp_valid && rsp_ready with no new accept clears rsp_valid next cycle.
- Simultaneous pop and accept: the new response replaces the old one with no bubble, giving throughput of 1 request/cycle.
- Read-after-write: a read accepted the cycle after a write to the same address returns the merged written data.
- Address wrap: none. Addresses between DEPTH and 2**ADDR_WIDTH-1 are errors; they do not alias.
- Request inputs are ignored when not accepted.

Decomposition:
- Shared package param_memory_pkg: FSM state enum (ST_CLEAR, ST_IDLE); BE width function DATA_WIDTH/8.
- One natural sub-module, mem_array_be: raw storage with clocked read/write and byte-enable merge; no handshake or reset.
- param_memory holds the FSM, clear counter, handshake and response register.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=1024 -> busy_clear=1 and req_ready=0 for exactly 1024 cycles; then read 0x3FF returns 0x0000.
- Write 0x1234 @0x000 and 0x4321 @0x3FF (be=2'b11), then read both -> rsp_rdata 0x1234, 0x4321; rsp_write=1 on the two write responses.
- Write 0xAAAA @5, then write 0x0055 with be=2'b01, read @5 -> 0xAA55.
- Hold rsp_ready=0 after a read of @0 -> rsp_valid, rsp_rdata=0x1234 stable and req_ready=0; release -> back-to-back reads of @0, @0x3FF complete one per cycle.
- DEPTH=768, read @0x300 -> rsp_err=1, rsp_rdata=0; word @0x000 is unchanged.
- Assert rst_n=0 at clear ptr=500 -> ptr restarts at 0; clear completes DEPTH cycles after reset release.
